// File: rtl/softusb_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softusb_tx_if                                                              |
// | Byte hand-over between the SIE (master) and the USB transmit PHY (slave).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface softusb_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/softusb_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softusb_tx                                                                 |
// | USB transmitter: SYNC, bit stuffing, NRZI, EOP at full or low speed.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module softusb_tx (
    input  logic        usb_clk,
    input  logic        usb_rst,
    softusb_tx_if.slave tx,
    input  logic        tx_low_speed,
    input  logic        low_speed,
    input  logic        generate_eop,
    output logic        txp,
    output logic        txm,
    output logic        txoe
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_EOP_SE0 = 3'd3,
        S_EOP_J   = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [4:0] FS_LAST      = 5'd3;
    localparam logic [4:0] LS_LAST      = 5'd31;

    state_t     state_q;
    logic [4:0] cnt_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic [2:0] ones_q;
    logic       lvl_q;      // 1 = J, 0 = K
    logic       rate_ls_q;
    logic       pol_ls_q;
    logic       txp_q;
    logic       txm_q;
    logic       txoe_q;
    logic       ready_q;
    logic       busy_q;

    logic       bit_end;
    logic       stuff_due;
    logic       byte_done;
    logic [4:0] cnt_d;
    logic       nbit_d;
    logic       lvl_d;
    logic [2:0] ones_d;

    // {txp, txm} for a J or K symbol under the given line polarity
    function automatic logic [1:0] line_level(input logic is_j, input logic ls);
        return (is_j ^ ls) ? 2'b10 : 2'b01;
    endfunction

    assign bit_end   = (cnt_q == (rate_ls_q ? LS_LAST : FS_LAST));
    assign stuff_due = (ones_q == 3'd6);
    assign byte_done = (bit_q == 3'd7) && !stuff_due;
    assign cnt_d     = bit_end ? 5'd0 : cnt_q + 5'd1;

    // Next bit on the wire: a forced 0 when stuffing, else the next data bit
    always_comb begin
        nbit_d = 1'b0;
        if (!stuff_due) begin
            nbit_d = byte_done ? tx.tx_data[0] : shift_q[bit_q + 3'd1];
        end
        lvl_d  = nbit_d ? lvl_q : ~lvl_q;
        ones_d = nbit_d ? ones_q + 3'd1 : 3'd0;
    end

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            shift_q   <= 8'd0;
            bit_q     <= 3'd0;
            ones_q    <= 3'd0;
            lvl_q     <= 1'b1;
            rate_ls_q <= 1'b0;
            pol_ls_q  <= 1'b0;
            txp_q     <= 1'b1;
            txm_q     <= 1'b0;
            txoe_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            cnt_q   <= (state_q == S_IDLE) ? 5'd0 : cnt_d;
            case (state_q)
                S_IDLE: begin
                    {txp_q, txm_q} <= line_level(1'b1, low_speed);
                    txoe_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    if (tx.tx_valid) begin
                        state_q        <= S_SYNC;
                        rate_ls_q      <= tx_low_speed;
                        pol_ls_q       <= low_speed;
                        shift_q        <= SYNC_PATTERN;
                        bit_q          <= 3'd0;
                        ones_q         <= 3'd0;
                        lvl_q          <= 1'b0;
                        {txp_q, txm_q} <= line_level(1'b0, low_speed);
                        txoe_q         <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (generate_eop) begin
                        state_q        <= S_EOP_SE0;
                        rate_ls_q      <= tx_low_speed;
                        pol_ls_q       <= low_speed;
                        bit_q          <= 3'd0;
                        {txp_q, txm_q} <= 2'b00;
                        txoe_q         <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                S_SYNC, S_DATA: begin
                    if (bit_end) begin
                        if (byte_done && !tx.tx_valid) begin
                            state_q        <= S_EOP_SE0;
                            bit_q          <= 3'd0;
                            {txp_q, txm_q} <= 2'b00;
                        end else begin
                            lvl_q          <= lvl_d;
                            ones_q         <= ones_d;
                            {txp_q, txm_q} <= line_level(lvl_d, pol_ls_q);
                            if (byte_done) begin
                                shift_q <= tx.tx_data;
                                bit_q   <= 3'd0;
                                ready_q <= 1'b1;
                                state_q <= S_DATA;
                            end else if (!stuff_due) begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end
                    end
                end
                S_EOP_SE0: begin
                    if (bit_end) begin
                        if (bit_q == 3'd1) begin
                            state_q        <= S_EOP_J;
                            bit_q          <= 3'd0;
                            {txp_q, txm_q} <= line_level(1'b1, pol_ls_q);
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                S_EOP_J: begin
                    if (bit_end) begin
                        state_q        <= S_IDLE;
                        {txp_q, txm_q} <= line_level(1'b1, low_speed);
                        txoe_q         <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign txp         = txp_q;
    assign txm         = txm_q;
    assign txoe        = txoe_q;
    assign tx.tx_ready = ready_q;
    assign tx.tx_busy  = busy_q;
endmodule
`default_nettype wire
